move_scheduler: RTL and testbench
=================================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameters: BASE_PERIOD, default 25_000_000, gravity period at Level 0 in clocks; STEP, default 1_500_000, period decrease per level; MIN_PERIOD, default 2_500_000, period floor; TIMEOUT, default 1_000_000, max clocks awaiting doneLogic.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have ports, in this order:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- Enable  in  1  game running.
- Level  in  4  speed level 0..15.
- KeyLeft, KeyRight, KeyDown, KeyDrop  in  1 each  synchronized, active-high button levels.
- doneLogic  in  1  move sequence complete, from the game logic FSM.
- LeftBlock, RightBlock, DownBlock, DropBlock  out  1 each  one-hot move command to the game logic FSM.
- Busy  out  1  command outstanding.
- Fault  out  1  one-cycle pulse on watchdog expiry.

Function
REQ-004 SHALL register each key and detect rising edges (current 1, previous 0); each edge SHALL set its pending bit: pendL, pendR, pendD or pendDrop.
REQ-005 SHALL clear the whole pending set when Enable=0, ignore key edges while Enable=0, and never accumulate: a pending bit is 1 or 0.
REQ-006 SHALL compute period = max(BASE_PERIOD - Level*STEP, MIN_PERIOD) using saturating 25-bit arithmetic; a negative intermediate SHALL yield MIN_PERIOD.
REQ-007 SHALL run the gravity counter only while Enable=1; on reaching period-1 it SHALL wrap to 0 and set pendG; a tick while pendG=1 SHALL be lost.
REQ-008 SHALL hold the gravity counter at 0 while Enable=0.
REQ-009 SHALL implement states IDLE, ISSUE and RELEASE.
REQ-010 In IDLE with Enable=1 and any pending bit set, SHALL grant by fixed priority Drop > Left > Right > Down(pendD|pendG), latch the command and go to ISSUE.
REQ-011 In ISSUE, SHALL drive exactly one command output high, held constant, and assert Busy.
REQ-012 In ISSUE, SHALL go to RELEASE on doneLogic=1, or on watchdog count = TIMEOUT-1, pulsing Fault in that case.
REQ-013 RELEASE SHALL last exactly one cycle with all command outputs low and Busy=1, then go to IDLE.
REQ-014 A grant SHALL clear the granted pending bit in the grant cycle; a Down grant SHALL clear both pendD and pendG.
REQ-015 A Down or Drop grant SHALL restart the gravity counter at 0 and clear pendG.
REQ-016 If the granted source has a new key edge in the grant cycle, its pending bit SHALL remain 1.
REQ-017 Enable falling during ISSUE SHALL NOT abort: the command SHALL be held until doneLogic or timeout.
REQ-018 Latency: key first sampled high in cycle n gives the command output high in cycle n+2 when in IDLE; doneLogic in cycle m gives outputs low in m+1, with the earliest next command in m+3.
REQ-019 doneLogic outside ISSUE SHALL be ignored.
REQ-020 The watchdog SHALL clear on every entry to ISSUE.

Reset
REQ-021 Reset=1 SHALL force state IDLE and clear all pending bits, the gravity counter, the watchdog and the key history registers.
REQ-022 Reset=1 SHALL drive all command outputs, Busy and Fault to 0 from the next cycle; Reset mid-ISSUE SHALL drop the command.
REQ-023 All outputs SHALL be registered.

Structure
REQ-024 Shared package tetris_pkg SHALL hold the state encoding, the command code (CMD_NONE, CMD_DROP, CMD_LEFT, CMD_RIGHT, CMD_DOWN) and the default period/timeout constants.
REQ-025 Sub-module gravity_timer SHALL contain the period computation and the gravity counter; its inputs SHALL be Enable, Level and restart, and its output SHALL be a tick pulse.

Verification (bench params BASE_PERIOD=20, STEP=2, MIN_PERIOD=4, TIMEOUT=50)
REQ-026 KeyLeft rises in cycle 10, doneLogic pulses in cycle 20 -> LeftBlock=1 in cycles 12..20, 0 from cycle 21, Busy=0 from cycle 22.
REQ-027 KeyDrop, KeyLeft and KeyRight rise in the same cycle -> grants in order Drop, Left, Right, each separated by RELEASE, with no overlap on the outputs.
REQ-028 Level=0 with no keys -> DownBlock granted every 20 cycles measured from the prior Down grant; Level=9 -> period floors at 4; Level=5 -> period 10.
REQ-029 Command issued and doneLogic never asserted -> Fault=1 for exactly one cycle at 50 cycles after ISSUE entry, then the command drops and the block returns to IDLE.
REQ-030 Reset asserted mid-ISSUE with pendR set -> all outputs 0 next cycle, pending cleared, no grant after Reset deasserts until a new key edge.
REQ-031 Enable dropped during ISSUE -> command held until doneLogic, then no further grants and the gravity counter stays at 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris move path: FSM states, move command codes,
// default gravity/watchdog timing and the gravity period helper.
package tetris_pkg;

   localparam int DEF_BASE_PERIOD = 25_000_000;
   localparam int DEF_STEP        = 1_500_000;
   localparam int DEF_MIN_PERIOD  = 2_500_000;
   localparam int DEF_TIMEOUT     = 1_000_000;
   localparam int PERIOD_W        = 25;

   localparam logic [39:0] PERIOD_SAT = 40'h00_01FF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_DROP  = 3'd1,
      CMD_LEFT  = 3'd2,
      CMD_RIGHT = 3'd3,
      CMD_DOWN  = 3'd4
   } cmd_t;

   // max(base - level*step, min), worked in 40 bits so nothing wraps, then
   // saturated to the 25-bit counter range.
   function automatic logic [PERIOD_W-1:0] calc_period(
      input logic [3:0] level,
      input int         base,
      input int         step_size,
      input int         min_period
   );
      logic [39:0] prod;
      logic [39:0] base_w;
      logic [39:0] min_w;
      logic [39:0] val;
      logic [PERIOD_W-1:0] result;
      prod   = 40'(level) * 40'(step_size);
      base_w = 40'(base);
      min_w  = 40'(min_period);
      if (prod >= base_w) begin
         val = min_w;
      end else if ((base_w - prod) < min_w) begin
         val = min_w;
      end else begin
         val = base_w - prod;
      end
      if (val > PERIOD_SAT) begin
         result = {PERIOD_W{1'b1}};
      end else begin
         result = val[PERIOD_W-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-dependent gravity counter; emits a one-cycle tick each time a period
// elapses while the game is running.
module gravity_timer
   import tetris_pkg::*;
#(
   parameter int BASE_PERIOD = DEF_BASE_PERIOD,
   parameter int STEP        = DEF_STEP,
   parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] level,
   input  logic       restart,
   output logic       tick
);

   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] last;
   logic [PERIOD_W-1:0] count;

   // Period from level; >= lets a level change to a shorter period wrap at once.
   always_comb begin
      period = calc_period(level, BASE_PERIOD, STEP, MIN_PERIOD);
      last   = period - PERIOD_W'(1);
      tick   = enable && !restart && (count >= last);
   end

   // A restart makes the grant cycle count 0 of the new period, so the next
   // count is 1 and grant-to-grant spacing equals the period.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= {PERIOD_W{1'b0}};
      end else if (!enable) begin
         count <= {PERIOD_W{1'b0}};
      end else if (restart) begin
         count <= (last == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}} : PERIOD_W'(1);
      end else if (tick) begin
         count <= {PERIOD_W{1'b0}};
      end else begin
         count <= count + PERIOD_W'(1);
      end
   end

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates key presses and gravity into one-hot move commands for the game
// logic FSM, holding each command until doneLogic or a watchdog timeout.
module move_scheduler
   import tetris_pkg::*;
#(
   parameter int BASE_PERIOD = DEF_BASE_PERIOD,
   parameter int STEP        = DEF_STEP,
   parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic       CLOCK_50,
   input  logic       Reset,
   input  logic       Enable,
   input  logic [3:0] Level,
   input  logic       KeyLeft,
   input  logic       KeyRight,
   input  logic       KeyDown,
   input  logic       KeyDrop,
   input  logic       doneLogic,
   output logic       LeftBlock,
   output logic       RightBlock,
   output logic       DownBlock,
   output logic       DropBlock,
   output logic       Busy,
   output logic       Fault
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t state;
   state_t next_state;
   cmd_t   cmd;
   cmd_t   next_cmd;
   cmd_t   grant;

   logic [3:0]      key_now;
   logic [3:0]      key_prev;
   logic [3:0]      key_edge;
   logic            pend_l;
   logic            pend_r;
   logic            pend_d;
   logic            pend_drop;
   logic            pend_g;
   logic            any_pend;
   logic            tick;
   logic            restart;
   logic            fault_next;
   logic [WD_W-1:0] wd;

   // Bit order: 0 left, 1 right, 2 down, 3 drop.
   assign key_now  = {KeyDrop, KeyDown, KeyRight, KeyLeft};
   assign key_edge = key_now & ~key_prev;
   assign any_pend = pend_drop | pend_l | pend_r | pend_d | pend_g;
   assign restart  = (grant == CMD_DROP) || (grant == CMD_DOWN);

   gravity_timer #(
      .BASE_PERIOD (BASE_PERIOD),
      .STEP        (STEP),
      .MIN_PERIOD  (MIN_PERIOD)
   ) u_gravity (
      .clk     (CLOCK_50),
      .reset   (Reset),
      .enable  (Enable),
      .level   (Level),
      .restart (restart),
      .tick    (tick)
   );

   // Key history for rising-edge detection.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         key_prev <= 4'b0000;
      end else begin
         key_prev <= key_now;
      end
   end

   // Grant arbitration and command sequencing.
   always_comb begin
      next_state = state;
      next_cmd   = cmd;
      grant      = CMD_NONE;
      fault_next = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Enable && any_pend) begin
               if (pend_drop) begin
                  grant = CMD_DROP;
               end else if (pend_l) begin
                  grant = CMD_LEFT;
               end else if (pend_r) begin
                  grant = CMD_RIGHT;
               end else begin
                  grant = CMD_DOWN;
               end
               next_cmd   = grant;
               next_state = ST_ISSUE;
            end else begin
               next_cmd   = CMD_NONE;
               next_state = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Enable is deliberately ignored here: a started move always completes.
            if (doneLogic) begin
               next_state = ST_RELEASE;
            end else if (wd == WD_LAST) begin
               next_state = ST_RELEASE;
               fault_next = 1'b1;
            end else begin
               next_state = ST_ISSUE;
            end
         end
         ST_RELEASE: begin
            next_state = ST_IDLE;
            next_cmd   = CMD_NONE;
         end
         default: begin
            next_state = ST_IDLE;
            next_cmd   = CMD_NONE;
         end
      endcase
   end

   // Pending requests: set by edges or gravity, cleared by their own grant or
   // by Enable=0. An edge in the grant cycle re-arms the bit.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         pend_l    <= 1'b0;
         pend_r    <= 1'b0;
         pend_d    <= 1'b0;
         pend_drop <= 1'b0;
         pend_g    <= 1'b0;
      end else if (!Enable) begin
         pend_l    <= 1'b0;
         pend_r    <= 1'b0;
         pend_d    <= 1'b0;
         pend_drop <= 1'b0;
         pend_g    <= 1'b0;
      end else begin
         pend_l    <= (pend_l    && (grant != CMD_LEFT))  || key_edge[0];
         pend_r    <= (pend_r    && (grant != CMD_RIGHT)) || key_edge[1];
         pend_d    <= (pend_d    && (grant != CMD_DOWN))  || key_edge[2];
         pend_drop <= (pend_drop && (grant != CMD_DROP))  || key_edge[3];
         pend_g    <= (pend_g    && !restart)             || tick;
      end
   end

   // State, watchdog and registered outputs decoded from the next state.
   always_ff @(posedge CLOCK_50) begin
      if (Reset) begin
         state      <= ST_IDLE;
         cmd        <= CMD_NONE;
         wd         <= {WD_W{1'b0}};
         LeftBlock  <= 1'b0;
         RightBlock <= 1'b0;
         DownBlock  <= 1'b0;
         DropBlock  <= 1'b0;
         Busy       <= 1'b0;
         Fault      <= 1'b0;
      end else begin
         state      <= next_state;
         cmd        <= next_cmd;
         wd         <= ((state == ST_ISSUE) && (next_state == ST_ISSUE)) ?
                       (wd + WD_W'(1)) : {WD_W{1'b0}};
         LeftBlock  <= (next_state == ST_ISSUE) && (next_cmd == CMD_LEFT);
         RightBlock <= (next_state == ST_ISSUE) && (next_cmd == CMD_RIGHT);
         DownBlock  <= (next_state == ST_ISSUE) && (next_cmd == CMD_DOWN);
         DropBlock  <= (next_state == ST_ISSUE) && (next_cmd == CMD_DROP);
         Busy       <= (next_state != ST_IDLE);
         Fault      <= fault_next;
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// Bench for move_scheduler: directed scenarios with hand-derived timing plus a
// randomized run against a behavioural model of the scheduling rules.
module tb_move_scheduler;

   localparam int BP = 20;
   localparam int ST = 2;
   localparam int MP = 4;
   localparam int TO = 50;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   = 1'b1;
   logic       en    = 1'b0;
   logic [3:0] lvl   = 4'd0;
   logic       kl    = 1'b0;
   logic       kr    = 1'b0;
   logic       kd    = 1'b0;
   logic       kdrop = 1'b0;
   logic       done  = 1'b0;
   logic       lb, rb, db, drb, busy, fault;

   int n_vec = 0;
   int n_err = 0;

   // Model: phase 0 idle / 1 issuing / 2 releasing; request index
   // 0 drop, 1 left, 2 right, 3 down key, 4 gravity.
   int         m_phase = 0;
   int         m_cmd   = 0;
   int         m_wd    = 0;
   int         m_cnt   = 0;
   bit [4:0]   m_pend  = 5'd0;
   bit [3:0]   m_prev  = 4'd0;
   logic [5:0] m_exp   = 6'd0;

   move_scheduler #(
      .BASE_PERIOD (BP),
      .STEP        (ST),
      .MIN_PERIOD  (MP),
      .TIMEOUT     (TO)
   ) dut (
      .CLOCK_50   (clk),
      .Reset      (rst),
      .Enable     (en),
      .Level      (lvl),
      .KeyLeft    (kl),
      .KeyRight   (kr),
      .KeyDown    (kd),
      .KeyDrop    (kdrop),
      .doneLogic  (done),
      .LeftBlock  (lb),
      .RightBlock (rb),
      .DownBlock  (db),
      .DropBlock  (drb),
      .Busy       (busy),
      .Fault      (fault)
   );

   // Observation order: {drop, left, right, down, busy, fault}.
   function automatic logic [5:0] obs_now();
      return {drb, lb, rb, db, busy, fault};
   endfunction

   task automatic model_step();
      bit [3:0] keys;
      bit [3:0] edg;
      int       g;
      int       p;
      bit       restart;
      bit       tk;
      bit       flt;
      keys = {kd, kr, kl, kdrop};
      if (rst) begin
         m_phase = 0; m_cmd = 0; m_wd = 0; m_cnt = 0;
         m_pend = 5'd0; m_prev = 4'd0; m_exp = 6'd0;
         return;
      end
      for (int i = 0; i < 4; i++) begin
         edg[i]    = en && keys[i] && !m_prev[i];
         m_prev[i] = keys[i];
      end
      g = -1;
      if (m_phase == 0 && en) begin
         for (int i = 0; i < 5; i++)
            if (g < 0 && m_pend[i]) g = (i == 4) ? 3 : i;
      end
      p = BP - int'(lvl) * ST;
      if (p < MP) p = MP;
      restart = (g == 0) || (g == 3);
      tk = en && !restart && (m_cnt >= p - 1);
      if (!en) m_cnt = 0;
      else if (restart) m_cnt = 1;
      else if (tk) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      for (int i = 0; i < 4; i++)
         m_pend[i] = en && ((m_pend[i] && g != i) || edg[i]);
      m_pend[4] = en && ((m_pend[4] && !restart) || tk);
      flt = 1'b0;
      case (m_phase)
         0: if (g >= 0) begin m_phase = 1; m_cmd = g; m_wd = 0; end
         1: begin
            if (done) m_phase = 2;
            else if (m_wd == TO - 1) begin m_phase = 2; flt = 1'b1; end
            else m_wd = m_wd + 1;
         end
         default: m_phase = 0;
      endcase
      m_exp = {m_phase == 1 && m_cmd == 0, m_phase == 1 && m_cmd == 1,
               m_phase == 1 && m_cmd == 2, m_phase == 1 && m_cmd == 3,
               m_phase != 0, flt};
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      int quiet;
      quiet = 0;
      en = 1'b0; rst = 1'b0;
      kl = 1'b0; kr = 1'b0; kd = 1'b0; kdrop = 1'b0;
      for (int i = 0; i < 200 && quiet < 3; i++) begin
         done  = lb | rb | db | drb;
         quiet = busy ? 0 : quiet + 1;
         step();
      end
      done = 1'b0;
      n_vec++;
      if (quiet < 3) begin
         n_err++;
         $display("FAIL flush_idle: busy=%0b, required 0 within 200 cycles", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if (obs_now() !== 6'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required 000000", obs_now());
         end
      end
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%0b, required 0", busy);
         end
      end
      flush();
   endtask

   task automatic test_left_latency();
      for (int c = 0; c <= 22; c++) begin
         logic [5:0] e;
         e = {1'b0, (c >= 12 && c <= 20), 1'b0, 1'b0, (c >= 12 && c <= 21), 1'b0};
         n_vec++;
         if (obs_now() !== e) begin
            n_err++;
            $display("FAIL left_latency c=%0d: got %b, required %b", c, obs_now(), e);
         end
         en = 1'b1; kl = (c >= 10 && c <= 13); done = (c == 20);
         step();
      end
      kl = 1'b0; done = 1'b0;
      flush();
   endtask

   task automatic test_priority();
      int         who[$];
      int         rise[$];
      logic [5:0] prev;
      int         exp_who[3];
      int         exp_rise[3];
      exp_who  = '{5, 4, 3};
      exp_rise = '{4, 7, 10};
      prev = 6'd0;
      for (int c = 0; c <= 16; c++) begin
         logic [5:0] o;
         o = obs_now();
         n_vec++;
         if ($countones(o[5:2]) > 1) begin
            n_err++;
            $display("FAIL priority_onehot c=%0d: got %b, required at most one command", c, o[5:2]);
         end
         for (int k = 2; k <= 5; k++)
            if (o[k] && !prev[k]) begin who.push_back(k); rise.push_back(c); end
         prev = o;
         en = 1'b1; kdrop = (c >= 2); kl = (c >= 2); kr = (c >= 2);
         done = |o[5:2];
         step();
      end
      n_vec++;
      if (who.size() != 3) begin
         n_err++;
         $display("FAIL priority_count: got %0d grants, required 3", who.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (who[i] != exp_who[i] || rise[i] != exp_rise[i]) begin
               n_err++;
               $display("FAIL priority_order #%0d: got bit %0d at c=%0d, required bit %0d at c=%0d",
                        i, who[i], rise[i], exp_who[i], exp_rise[i]);
            end
         end
      end
      flush();
   endtask

   task automatic test_gravity();
      int levels[3];
      levels = '{0, 5, 9};
      for (int li = 0; li < 3; li++) begin
         int   p;
         int   rises[$];
         logic prev_db;
         rises.delete();
         prev_db = 1'b0;
         p = BP - levels[li] * ST;
         if (p < MP) p = MP;
         lvl = 4'(levels[li]);
         for (int c = 0; c <= 4 * p + 1; c++) begin
            if (db && !prev_db) rises.push_back(c);
            prev_db = db;
            en = 1'b1; done = db;
            step();
         end
         n_vec++;
         if (rises.size() != 4) begin
            n_err++;
            $display("FAIL gravity_count L=%0d: got %0d grants, required 4", levels[li], rises.size());
         end
         for (int k = 0; k < rises.size(); k++) begin
            n_vec++;
            if (rises[k] != (k + 1) * p + 1) begin
               n_err++;
               $display("FAIL gravity_time L=%0d #%0d: got c=%0d, required c=%0d",
                        levels[li], k, rises[k], (k + 1) * p + 1);
            end
         end
         flush();
      end
      lvl = 4'd0;
   endtask

   task automatic test_timeout();
      for (int c = 0; c <= 54; c++) begin
         logic [5:0] e;
         e = {1'b0, 1'b0, (c >= 3 && c <= 52), 1'b0, (c >= 3 && c <= 53), (c == 53)};
         n_vec++;
         if (obs_now() !== e) begin
            n_err++;
            $display("FAIL timeout c=%0d: got %b, required %b", c, obs_now(), e);
         end
         en = 1'b1; kr = (c == 1); done = 1'b0;
         step();
      end
      flush();
   endtask

   task automatic test_reset_mid_issue();
      for (int c = 0; c <= 23; c++) begin
         logic [5:0] e;
         if (c >= 3 && c <= 5) e = 6'b010010;
         else if (c == 23) e = 6'b001010;
         else e = 6'b000000;
         n_vec++;
         if (obs_now() !== e) begin
            n_err++;
            $display("FAIL reset_mid_issue c=%0d: got %b, required %b", c, obs_now(), e);
         end
         en = 1'b1; kl = (c == 1); kr = (c == 1 || c == 21);
         rst = (c == 5); done = 1'b0;
         step();
      end
      rst = 1'b0;
      flush();
   endtask

   task automatic test_enable_drop();
      for (int c = 0; c <= 62; c++) begin
         logic [5:0] e;
         if (c >= 3 && c <= 10) e = 6'b000110;
         else if (c == 11) e = 6'b000010;
         else if (c == 62) e = 6'b000110;
         else e = 6'b000000;
         n_vec++;
         if (obs_now() !== e) begin
            n_err++;
            $display("FAIL enable_drop c=%0d: got %b, required %b", c, obs_now(), e);
         end
         en = (c < 5) || (c >= 41); kd = (c == 1); kl = (c == 4); done = (c == 10);
         step();
      end
      flush();
   endtask

   task automatic test_random();
      int done_rate;
      rst = 1'b1; step(); step();
      rst = 1'b0; en = 1'b1;
      done_rate = 4;
      for (int i = 0; i < 3000; i++) begin
         n_vec++;
         if (obs_now() !== m_exp) begin
            n_err++;
            $display("FAIL random i=%0d: got %b, required %b", i, obs_now(), m_exp);
         end
         if (i % 500 == 0) done_rate = (i % 1000 == 0) ? 3 : 80;
         rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 59) == 0) en = ~en;
         if ($urandom_range(0, 99) == 0) lvl = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) kl = ~kl;
         if ($urandom_range(0, 5) == 0) kr = ~kr;
         if ($urandom_range(0, 5) == 0) kd = ~kd;
         if ($urandom_range(0, 7) == 0) kdrop = ~kdrop;
         done = ($urandom_range(0, done_rate - 1) == 0);
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_left_latency();
      test_priority();
      test_gravity();
      test_timeout();
      test_reset_mid_issue();
      test_enable_drop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
